// File: rtl/int_multi_fsm.sv
// rtl/int_multi_fsm.sv - per-channel debounced interrupt qualifier with saturating event counters
// Optional falling-event pulse output enabled by defining INT_FALL_PULSE_EN.
module int_multi_fsm #(
   parameter int CH         = 2,
   parameter int STABLE_CYC = 3,
   parameter int CNT_W      = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CH-1:0]       int_sig,
   input  logic [CH-1:0]       cnt_clr,
   output logic [CH-1:0]       count,
   output logic [CH-1:0]       fall_pulse,
   output logic [CH-1:0]       level,
   output logic [CH*CNT_W-1:0] evt_cnt,
   output logic                any_evt
);

   localparam int              DW        = $clog2(STABLE_CYC + 1);
   localparam logic [DW-1:0]   DCNT_ONE  = DW'(1);
   localparam logic [DW-1:0]   DCNT_LAST = DW'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] EVT_ONE  = CNT_W'(1);
   localparam bit              SINGLE    = (STABLE_CYC == 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_QUAL,
      S_OUT_EN,
      S_ACTIVE,
      S_REL
   } state_t;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      state_t            state_q, state_d;
      logic [DW-1:0]     dcnt_q, dcnt_d;
      logic [CNT_W-1:0]  evt_q;
      logic              hi;

      assign hi = int_sig[i];

      always_comb begin
         state_d = state_q;
         dcnt_d  = dcnt_q;
         case (state_q)
            S_IDLE: begin
               if (hi) begin
                  if (SINGLE) begin
                     state_d = S_OUT_EN;
                  end else begin
                     state_d = S_QUAL;
                     dcnt_d  = DCNT_ONE;
                  end
               end
            end
            S_QUAL: begin
               if (!hi) begin
                  state_d = S_IDLE;
                  dcnt_d  = '0;
               end else if (dcnt_q == DCNT_LAST) begin
                  state_d = S_OUT_EN;
                  dcnt_d  = '0;
               end else begin
                  dcnt_d = dcnt_q + DCNT_ONE;
               end
            end
            S_OUT_EN, S_ACTIVE: begin
               if (hi) begin
                  state_d = S_ACTIVE;
               end else if (SINGLE) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_REL;
                  dcnt_d  = DCNT_ONE;
               end
            end
            S_REL: begin
               // A high sample during release returns to ACTIVE without a new pulse
               if (hi) begin
                  state_d = S_ACTIVE;
                  dcnt_d  = '0;
               end else if (dcnt_q == DCNT_LAST) begin
                  state_d = S_IDLE;
                  dcnt_d  = '0;
               end else begin
                  dcnt_d = dcnt_q + DCNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               dcnt_d  = '0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
         end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
         end
      end

      // Clear wins over the pending increment but still records that event
      always_ff @(posedge clk) begin
         if (reset) begin
            evt_q <= '0;
         end else if (cnt_clr[i]) begin
            evt_q <= (state_q == S_OUT_EN) ? EVT_ONE : '0;
         end else if ((state_q == S_OUT_EN) && (evt_q != '1)) begin
            evt_q <= evt_q + EVT_ONE;
         end
      end

      assign count[i] = (state_q == S_OUT_EN);
      assign level[i] = (state_q == S_OUT_EN) || (state_q == S_ACTIVE) || (state_q == S_REL);
      assign evt_cnt[i*CNT_W +: CNT_W] = evt_q;

`ifdef INT_FALL_PULSE_EN
      logic fall_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            fall_q <= 1'b0;
         end else begin
            fall_q <= level[i] && (state_d == S_IDLE);
         end
      end

      assign fall_pulse[i] = fall_q;
`else
      assign fall_pulse[i] = 1'b0;
`endif
   end

   assign any_evt = |count;

endmodule

// File: tb/tb_int_multi_fsm.sv
// tb/tb_int_multi_fsm.sv - randomized and directed bench for int_multi_fsm against a run-length debounce model
module tb_int_multi_fsm;

   localparam int CH     = 2;
   localparam int STABLE = 3;
   localparam int CNT_W  = 4;
   localparam int MAXC   = (1 << CNT_W) - 1;
   localparam int VW     = 3*CH + CH*CNT_W + 1;
`ifdef INT_FALL_PULSE_EN
   localparam bit FALL_EN = 1'b1;
`else
   localparam bit FALL_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [CH-1:0]       int_sig = '0;
   logic [CH-1:0]       cnt_clr = '0;
   logic [CH-1:0]       count;
   logic [CH-1:0]       fall_pulse;
   logic [CH-1:0]       level;
   logic [CH*CNT_W-1:0] evt_cnt;
   logic                any_evt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: level flips after STABLE consecutive samples disagreeing with it
   int m_run [CH];
   bit m_lvl [CH];
   bit m_cnt [CH];
   bit m_fall[CH];
   int m_evt [CH];

   int_multi_fsm #(.CH(CH), .STABLE_CYC(STABLE), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .int_sig    (int_sig),
      .cnt_clr    (cnt_clr),
      .count      (count),
      .fall_pulse (fall_pulse),
      .level      (level),
      .evt_cnt    (evt_cnt),
      .any_evt    (any_evt)
   );

   always #5 clk = ~clk;

   wire [VW-1:0] obs = {count, level, fall_pulse, evt_cnt, any_evt};

   function automatic logic [VW-1:0] exp_vec();
      logic [CH-1:0]       ec, el, ef;
      logic [CH*CNT_W-1:0] ee;
      for (int k = 0; k < CH; k++) begin
         ec[k] = m_cnt[k];
         el[k] = m_lvl[k];
         ef[k] = m_fall[k];
         ee[k*CNT_W +: CNT_W] = CNT_W'(m_evt[k]);
      end
      return {ec, el, ef, ee, |ec};
   endfunction

   task automatic step(input logic [CH-1:0] sig, input logic [CH-1:0] clr, input bit rst);
      int_sig = sig;
      cnt_clr = clr;
      reset   = rst;
      @(posedge clk);
      for (int k = 0; k < CH; k++) begin
         if (rst) begin
            m_run[k] = 0; m_lvl[k] = 0; m_cnt[k] = 0; m_fall[k] = 0; m_evt[k] = 0;
         end else begin
            if (clr[k])                          m_evt[k] = m_cnt[k] ? 1 : 0;
            else if (m_cnt[k] && m_evt[k] < MAXC) m_evt[k] = m_evt[k] + 1;
            m_cnt[k]  = 0;
            m_fall[k] = 0;
            if (sig[k] != m_lvl[k]) begin
               m_run[k] = m_run[k] + 1;
               if (m_run[k] == STABLE) begin
                  m_lvl[k]  = sig[k];
                  m_run[k]  = 0;
                  m_cnt[k]  = sig[k];
                  m_fall[k] = FALL_EN && !sig[k];
               end
            end else begin
               m_run[k] = 0;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(2'b11, 2'b00, 1'b1);
         n_checks++;
         if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset cyc=%0d got=%h want=0", i, obs);
         end
      end
      step(2'b00, 2'b00, 1'b0);
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 7; i++) begin
         step((i < 2) ? 2'b01 : 2'b00, 2'b00, 1'b0);
         n_checks++;
         if (count[0] !== 1'b0 || level[0] !== 1'b0 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL glitch cyc=%0d got=%h want=%h", i, obs, exp_vec());
         end
      end
      n_checks++;
      if (evt_cnt[CNT_W-1:0] !== '0) begin
         n_fail++;
         $display("FAIL glitch_evt got=%0d want=0", evt_cnt[CNT_W-1:0]);
      end
   endtask

   task automatic test_hold();
      int pulses = 0;
      for (int i = 1; i <= 10; i++) begin
         step(2'b01, 2'b00, 1'b0);
         pulses += count[0];
         n_checks++;
         if (count[0] !== (i == 3) || level[0] !== (i >= 3) || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL hold cyc=%0d count=%b level=%b got=%h want=%h", i, count[0], level[0], obs, exp_vec());
         end
      end
      n_checks++;
      if (pulses != 1 || evt_cnt[CNT_W-1:0] !== 4'd1) begin
         n_fail++;
         $display("FAIL hold_evt pulses=%0d evt=%0d want 1/1", pulses, evt_cnt[CNT_W-1:0]);
      end
      for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b0);
   endtask

   task automatic test_dropout();
      int pulses = 0;
      logic [CH-1:0] pat [11] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                                  2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
      for (int i = 0; i < 11; i++) begin
         step(pat[i], 2'b00, 1'b0);
         pulses += count[1];
         n_checks++;
         if ((i >= 2 && level[1] !== 1'b1) || fall_pulse[1] !== 1'b0 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL dropout cyc=%0d level=%b fall=%b got=%h want=%h", i, level[1], fall_pulse[1], obs, exp_vec());
         end
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL dropout_pulses got=%0d want=1", pulses);
      end
      for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b0);
   endtask

   task automatic test_release();
      for (int i = 0; i < 4; i++) step(2'b01, 2'b00, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         step(2'b00, 2'b00, 1'b0);
         n_checks++;
         if (level[0] !== (k < 3) || fall_pulse[0] !== (FALL_EN && k == 3) || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL release low=%0d level=%b fall=%b got=%h want=%h", k, level[0], fall_pulse[0], obs, exp_vec());
         end
      end
   endtask

   task automatic test_saturate();
      step(2'b00, 2'b01, 1'b0);
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 6; i++) begin
            step((i < 3) ? 2'b01 : 2'b00, 2'b00, 1'b0);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL saturate rise=%0d cyc=%0d got=%h want=%h", r, i, obs, exp_vec());
            end
         end
      end
      n_checks++;
      if (evt_cnt[CNT_W-1:0] !== 4'd15) begin
         n_fail++;
         $display("FAIL sat_value got=%0d want=15", evt_cnt[CNT_W-1:0]);
      end
      for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 1'b0);
      step(2'b00, 2'b01, 1'b0);
      n_checks++;
      if (evt_cnt[CNT_W-1:0] !== 4'd1) begin
         n_fail++;
         $display("FAIL clr_on_inc got=%0d want=1", evt_cnt[CNT_W-1:0]);
      end
      step(2'b00, 2'b01, 1'b0);
      n_checks++;
      if (evt_cnt[CNT_W-1:0] !== 4'd0 || obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL clr_plain got=%0d want=0", evt_cnt[CNT_W-1:0]);
      end
      for (int i = 0; i < 2; i++) step(2'b00, 2'b00, 1'b0);
   endtask

   task automatic test_reset_mid();
      step(2'b10, 2'b00, 1'b0);
      step(2'b10, 2'b00, 1'b0);
      step(2'b10, 2'b00, 1'b1);
      n_checks++;
      if (count[1] !== 1'b0 || level[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_abort count=%b level=%b want 0/0", count[1], level[1]);
      end
      for (int k = 1; k <= 5; k++) begin
         step(2'b10, 2'b00, 1'b0);
         n_checks++;
         if (count[1] !== (k == 3) || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_mid sample=%0d count=%b got=%h want=%h", k, count[1], obs, exp_vec());
         end
      end
      for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b0);
   endtask

   task automatic test_random();
      logic [CH-1:0] sig = '0;
      logic [CH-1:0] clr;
      int hold [CH];
      bit rst;
      for (int k = 0; k < CH; k++) hold[k] = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < CH; k++) begin
            if (hold[k] == 0) begin
               sig[k]  = ~sig[k];
               hold[k] = $urandom_range(1, 6);
            end
            hold[k]--;
            clr[k] = ($urandom_range(0, 15) == 0);
         end
         rst = ($urandom_range(0, 299) == 0);
         step(sig, clr, rst);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc=%0d in=%b clr=%b got=%h want=%h", i, sig, clr, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_hold();
      test_dropout();
      test_release();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/int_multi_fsm.md
INT_MULTI_FSM -- requirements
Module: int_multi_fsm

Interface
REQ-001 The block SHALL have parameter CH, default 2, giving the number of independent interruption channels (1..16).
REQ-002 The block SHALL have parameter STABLE_CYC, default 3, giving the consecutive-sample debounce length (1..255).
REQ-003 The block SHALL have parameter CNT_W, default 4, giving the per-channel event counter width (1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port int_sig, input, CH bits: raw interruption levels, one per channel, already synchronous to clk.
REQ-007 The block SHALL have port cnt_clr, input, CH bits: per-channel event counter clear strobe.
REQ-008 The block SHALL have port count, output, CH bits: one-cycle debounced rising-event pulse per channel.
REQ-009 The block SHALL have port fall_pulse, output, CH bits: one-cycle debounced falling-event pulse per channel.
REQ-010 The block SHALL have port level, output, CH bits: debounced channel level.
REQ-011 The block SHALL have port evt_cnt, output, CH*CNT_W bits: per-channel event counters, channel i at bits [i*CNT_W +: CNT_W].
REQ-012 The block SHALL have port any_evt, output, 1 bit: OR of all count bits.

Function
REQ-013 Each channel SHALL run an independent Moore FSM with states IDLE, QUAL, OUT_EN, ACTIVE, REL and a debounce counter of clog2(STABLE_CYC+1) bits.
REQ-014 IDLE: int_sig high -> QUAL with dcnt=1, or directly OUT_EN if STABLE_CYC=1; low -> stay.
REQ-015 QUAL: high with dcnt=STABLE_CYC-1 -> OUT_EN; high otherwise -> dcnt+1; low -> IDLE (glitch rejected, no pulse).
REQ-016 OUT_EN: high -> ACTIVE; low -> REL with dcnt=1, or IDLE if STABLE_CYC=1.
REQ-017 ACTIVE: low -> REL with dcnt=1, or IDLE if STABLE_CYC=1; high -> stay.
REQ-018 REL: low with dcnt=STABLE_CYC-1 -> IDLE; low otherwise -> dcnt+1; high -> ACTIVE (no new pulse).
REQ-019 count[i] SHALL be high exactly while channel i is in OUT_EN: one cycle per qualified rise, first asserted at the edge that samples the STABLE_CYC-th consecutive high.
REQ-020 level[i] SHALL be high in OUT_EN, ACTIVE and REL, low in IDLE and QUAL.
REQ-021 evt_cnt[i] SHALL increment by 1 in the cycle after count[i] is high, saturating at 2^CNT_W-1 (no wrap).
REQ-022 cnt_clr[i] SHALL zero evt_cnt[i] at the next edge; if it coincides with the increment edge, the result SHALL be 1.
REQ-023 any_evt SHALL be combinational OR of count; channels SHALL NOT interact.

Reset
REQ-024 With reset high at a clock edge, every channel SHALL enter IDLE with dcnt=0 and evt_cnt=0; count, fall_pulse, level and any_evt SHALL be 0 in the following cycle.
REQ-025 Reset asserted mid-qualification or mid-pulse SHALL abort it with no pulse; after release, a still-high int_sig SHALL requalify from IDLE for a full STABLE_CYC samples.

Configuration
REQ-026 With macro INT_FALL_PULSE_EN defined, fall_pulse[i] SHALL be high for exactly one cycle after each transition into IDLE from OUT_EN, ACTIVE or REL.
REQ-027 Without INT_FALL_PULSE_EN, fall_pulse SHALL be tied to 0 and its generation logic SHALL be absent; all other behaviour SHALL be identical.

Verification (CH=2, STABLE_CYC=3, CNT_W=4)
REQ-028 int_sig[0] high 2 cycles then low -> no count[0], level[0] stays 0, evt_cnt[0]=0.
REQ-029 int_sig[0] held high 10 cycles -> count[0] single pulse in cycle 3 after the first high sample, level[0] high from then, evt_cnt[0]=1.
REQ-030 int_sig[1] high, one-cycle low dropout in ACTIVE, high again -> no second count[1], level[1] stays 1, no fall_pulse[1].
REQ-031 20 qualified rises on channel 0 -> evt_cnt[0]=15 (saturated); cnt_clr[0] on the increment edge -> evt_cnt[0]=1.
REQ-032 Reset pulsed while channel 1 is in QUAL with int_sig[1] still high -> no pulse; count[1] first asserts 3 samples after reset deasserts.
REQ-033 With INT_FALL_PULSE_EN, release held low 3 cycles after ACTIVE -> fall_pulse[0] one cycle, level[0] to 0 together; without the macro fall_pulse stays 0.
